etpu_wb_master: RTL and testbench

- Wishbone classic initiator that drives one complete edu_tpu job over the Caravel-style bus.
- On a start pulse it performs three phases in order:
  - writes 4 weight words,
  - streams NUM_IN input words,
  - reads back NUM_RD result words.
- All traffic goes to a single slave address. Used as an on-chip test sequencer and as the verification stimulus engine for the TPU slave.

---
 rtl/etpu_wb_master.sv | 186 ++++++++++++++++++
 tb/tb_etpu_wb_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etpu_wb_master.sv
// Wishbone classic initiator that runs one edu_tpu job: 4 weight writes, NUM_IN input
// writes, then NUM_RD result reads, all to BASE_ADDRESS with an idle gap after each transfer.
module etpu_wb_master #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int unsigned NUM_IN       = 7,
  parameter int unsigned NUM_RD       = 5,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                caravel_wb_clk_i,
  input  logic                caravel_wb_rst_i,
  input  logic                start_i,
  input  logic [127:0]        weights_i,
  input  logic [32*NUM_IN-1:0] inputs_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [32*NUM_RD-1:0] result_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [3:0]          wb_sel_o,
  output logic [31:0]         wb_adr_o,
  output logic [31:0]         wb_dat_o,
  input  logic [31:0]         wb_dat_i,
  input  logic                wb_ack_i
);

  localparam int unsigned CNT_MAX = (NUM_IN > NUM_RD) ? ((NUM_IN > 4) ? NUM_IN : 4)
                                                      : ((NUM_RD > 4) ? NUM_RD : 4);
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, WR_W, WR_IN, RD, GAP, FINISH} state_t;

  state_t              state;
  state_t              phase;
  state_t              nxt_phase;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       nxt_cnt;
  logic [TW-1:0]       to_cnt;
  logic [GW-1:0]       gap_cnt;
  logic [127:0]        w_snap;
  logic [32*NUM_IN-1:0] in_snap;
  logic                last_word;
  logic [31:0]         nxt_dat;
  logic                xfer_ack;
  logic                advance;

  // Next word/phase selection, shared by the gap exit and the zero-gap ack path
  always_comb begin
    case (phase)
      WR_W:    last_word = (cnt == CW'(3));
      WR_IN:   last_word = (cnt == CW'(NUM_IN - 1));
      RD:      last_word = (cnt == CW'(NUM_RD - 1));
      default: last_word = 1'b1;
    endcase
    nxt_phase = phase;
    nxt_cnt   = cnt + 1'b1;
    if (last_word) begin
      nxt_cnt = '0;
      case (phase)
        WR_W:    nxt_phase = WR_IN;
        WR_IN:   nxt_phase = RD;
        default: nxt_phase = FINISH;
      endcase
    end
    nxt_dat = '0;
    if (nxt_phase == WR_W)
      nxt_dat = w_snap[32*nxt_cnt +: 32];
    else if (nxt_phase == WR_IN)
      nxt_dat = in_snap[32*nxt_cnt +: 32];
  end

  always_comb begin
    xfer_ack = wb_stb_o && wb_ack_i;
    if (GAP_CYCLES == 0)
      advance = xfer_ack;
    else
      advance = (state == GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));
  end

  always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_i) begin
    if (!caravel_wb_rst_i) begin
      state    <= IDLE;
      phase    <= IDLE;
      cnt      <= '0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
      w_snap   <= '0;
      in_snap  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      result_o <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            w_snap   <= weights_i;
            in_snap  <= inputs_i;
            busy_o   <= 1'b1;
            err_o    <= 1'b0;
            result_o <= '0;
            state    <= WR_W;
            phase    <= WR_W;
            cnt      <= '0;
            to_cnt   <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_sel_o <= 4'hF;
            wb_adr_o <= BASE_ADDRESS;
            wb_dat_o <= weights_i[31:0];
          end
        end
        WR_W, WR_IN, RD: begin
          if (xfer_ack) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            if (state == RD)
              result_o[32*cnt +: 32] <= wb_dat_i;
            if (GAP_CYCLES != 0) begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            err_o    <= 1'b1;
            cnt      <= '0;
            state    <= FINISH;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (!advance)
            gap_cnt <= gap_cnt + 1'b1;
        end
        FINISH: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Placed after the case so it overrides the ack-cycle bus release when the next
      // transfer starts immediately (zero gap) or the gap has just expired.
      if (advance) begin
        cnt <= nxt_cnt;
        if (nxt_phase == FINISH) begin
          state <= FINISH;
        end else begin
          state    <= nxt_phase;
          phase    <= nxt_phase;
          to_cnt   <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= (nxt_phase != RD);
          wb_sel_o <= 4'hF;
          wb_adr_o <= BASE_ADDRESS;
          wb_dat_o <= nxt_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_etpu_wb_master.sv
// Directed bench for etpu_wb_master: negedge-driven Wishbone slave models for a GAP=4
// instance and a GAP=0 instance, with immediate-assertion checks.
module tb_etpu_wb_master;
  localparam int unsigned NUM_IN = 7;
  localparam int unsigned NUM_RD = 5;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] IDLE_D = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic                 start0 = 1'b0;
  logic [127:0]         weights = '0;
  logic [32*NUM_IN-1:0] inputs = '0;

  logic                 busy, done, err, cyc, stb, we;
  logic [32*NUM_RD-1:0] result;
  logic [3:0]           sel;
  logic [31:0]          adr, dat_o;
  logic [31:0]          dat_i = IDLE_D;
  logic                 ack = 1'b0;

  logic                 busy0, done0, err0, cyc0, stb0, we0;
  logic [32*NUM_RD-1:0] result0;
  logic [3:0]           sel0;
  logic [31:0]          adr0, dat_o0;
  logic [31:0]          dat_i0 = IDLE_D;
  logic                 ack0 = 1'b0;

  etpu_wb_master dut (
    .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst_n), .start_i(start),
    .weights_i(weights), .inputs_i(inputs), .busy_o(busy), .done_o(done), .err_o(err),
    .result_o(result), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_ack_i(ack)
  );

  etpu_wb_master #(.GAP_CYCLES(0)) dut0 (
    .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst_n), .start_i(start0),
    .weights_i(weights), .inputs_i(inputs), .busy_o(busy0), .done_o(done0), .err_o(err0),
    .result_o(result0), .wb_cyc_o(cyc0), .wb_stb_o(stb0), .wb_we_o(we0), .wb_sel_o(sel0),
    .wb_adr_o(adr0), .wb_dat_o(dat_o0), .wb_dat_i(dat_i0), .wb_ack_i(ack0)
  );

  int checks = 0;
  int errors = 0;

  // Slave/monitor state for dut
  int xfer_n, rd_n, wcnt, run_len, last_run, idle_len, gap_min, gap_max, unstable;
  int busy_cnt, done_cnt;
  int stall_idx = -1, stall_extra = 0, never_idx = -1;
  bit seen, prev_stb;
  logic        ref_we;
  logic [31:0] ref_adr, ref_dat;
  logic        log_we  [32];
  logic [3:0]  log_sel [32];
  logic [31:0] log_adr [32];
  logic [31:0] log_dat [32];

  // Slave/monitor state for dut0
  int x0, rd0, w0, busy0_cnt, low0, done0_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0; dat_i = IDLE_D; wcnt = 0; prev_stb = 1'b0; run_len = 0;
    end else begin
      if (ack) begin
        ack = 1'b0; dat_i = IDLE_D; wcnt = 0;
      end else if (stb) begin
        if (wcnt == 0) begin
          ref_we = we; ref_adr = adr; ref_dat = dat_o;
        end else if (we !== ref_we || adr !== ref_adr || dat_o !== ref_dat || cyc !== 1'b1) begin
          unstable++;
        end
        if (xfer_n != never_idx && wcnt >= 1 + ((xfer_n == stall_idx) ? stall_extra : 0)) begin
          ack = 1'b1;
          if (xfer_n < 32) begin
            log_we[xfer_n] = we; log_sel[xfer_n] = sel;
            log_adr[xfer_n] = adr; log_dat[xfer_n] = dat_o;
          end
          if (!we) begin
            dat_i = 32'hD0D0_0000 + 32'(rd_n);
            rd_n++;
          end
          xfer_n++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      if (stb) begin
        if (!prev_stb && seen) begin
          if (idle_len < gap_min) gap_min = idle_len;
          if (idle_len > gap_max) gap_max = idle_len;
        end
        run_len++;
      end else if (prev_stb) begin
        last_run = run_len; run_len = 0; seen = 1'b1; idle_len = 1;
      end else if (seen) begin
        idle_len++;
      end
      prev_stb = stb;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ack0 = 1'b0; dat_i0 = IDLE_D; w0 = 0;
    end else begin
      if (stb0 && !ack0) begin
        if (w0 >= 1) begin
          ack0 = 1'b1;
          if (!we0) begin
            dat_i0 = 32'hE0E0_0000 + 32'(rd0);
            rd0++;
          end
          x0++;
        end else begin
          w0++;
        end
      end else if (ack0) begin
        ack0 = 1'b0; dat_i0 = IDLE_D; w0 = stb0 ? 1 : 0;
      end else begin
        w0 = 0;
      end
      if (busy0) begin
        busy0_cnt++;
        if (!stb0) low0++;
      end
      if (done0) done0_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_stats();
    xfer_n = 0; rd_n = 0; gap_min = 1000; gap_max = -1; unstable = 0;
    busy_cnt = 0; done_cnt = 0; seen = 1'b0; last_run = 0; idle_len = 0;
    x0 = 0; rd0 = 0; busy0_cnt = 0; low0 = 0; done0_cnt = 0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      step();
      n++;
    end
    chk("done_within_budget", 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cyc"}, 64'(cyc), 64'd0);
    chk({tag, "_stb"}, 64'(stb), 64'd0);
    chk({tag, "_we"}, 64'(we), 64'd0);
    chk({tag, "_sel"}, 64'(sel), 64'd0);
    chk({tag, "_adr"}, 64'(adr), 64'd0);
    chk({tag, "_dat"}, 64'(dat_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_result"}, 64'(result == '0), 64'd1);
  endtask

  logic [31:0] exp_w [16];
  logic [127:0]         w_orig;
  logic [32*NUM_IN-1:0] in_orig;

  initial begin
    w_orig = {32'h100F_0E0D, 32'h0C0B_0A09, 32'h0807_0605, 32'h0403_0201};
    for (int k = 0; k < int'(NUM_IN); k++) in_orig[32*k +: 32] = 32'hCAFE_0000 + 32'(k);
    for (int i = 0; i < 16; i++)
      exp_w[i] = (i < 4) ? w_orig[32*i +: 32] : (i < 11) ? in_orig[32*(i-4) +: 32] : 32'h0;
    weights = w_orig;
    inputs  = in_orig;
    clear_stats();

    // Reset values
    repeat (2) step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Job 1: happy path, 10 extra wait cycles on write 2, input snapshot check
    clear_stats();
    stall_idx = 2; stall_extra = 10; never_idx = -1;
    start0 = 1'b1;
    pulse_start();
    start0 = 1'b0;
    weights = ~w_orig;
    inputs  = ~in_orig;
    wait_done(400);
    repeat (4) step();
    chk("j1_xfers", 64'(xfer_n), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("j1_we_%0d", i), 64'(log_we[i]), 64'(i < 11));
      chk($sformatf("j1_adr_%0d", i), 64'(log_adr[i]), 64'(BASE));
      chk($sformatf("j1_sel_%0d", i), 64'(log_sel[i]), 64'hF);
      chk($sformatf("j1_dat_%0d", i), 64'(log_dat[i]), 64'(exp_w[i]));
    end
    for (int k = 0; k < int'(NUM_RD); k++)
      chk($sformatf("j1_result_%0d", k), 64'(result[32*k +: 32]), 64'(32'hD0D0_0000 + 32'(k)));
    chk("j1_done_pulses", 64'(done_cnt), 64'd1);
    chk("j1_err", 64'(err), 64'd0);
    chk("j1_busy_end", 64'(busy), 64'd0);
    chk("j1_gap_min", 64'(gap_min), 64'd4);
    chk("j1_gap_max", 64'(gap_max), 64'd4);
    chk("j1_stall_stable", 64'(unstable), 64'd0);
    chk("j1_busy_cycles", 64'(busy_cnt), 64'd107);
    chk("g0_xfers", 64'(x0), 64'd16);
    chk("g0_busy_cycles", 64'(busy0_cnt), 64'd33);
    chk("g0_stb_low_busy", 64'(low0), 64'd1);
    chk("g0_done_pulses", 64'(done0_cnt), 64'd1);
    for (int k = 0; k < int'(NUM_RD); k++)
      chk($sformatf("g0_result_%0d", k), 64'(result0[32*k +: 32]), 64'(32'hE0E0_0000 + 32'(k)));

    // Job 2: read 3 never acked -> timeout
    weights = w_orig;
    inputs  = in_orig;
    clear_stats();
    stall_idx = -1; never_idx = 14;
    pulse_start();
    wait_done(600);
    repeat (3) step();
    chk("j2_err", 64'(err), 64'd1);
    chk("j2_done_pulses", 64'(done_cnt), 64'd1);
    chk("j2_acked_xfers", 64'(xfer_n), 64'd14);
    chk("j2_stb_len", 64'(last_run), 64'd255);
    chk("j2_stb_after", 64'(stb), 64'd0);
    chk("j2_busy_end", 64'(busy), 64'd0);
    for (int k = 0; k < int'(NUM_RD); k++)
      chk($sformatf("j2_result_%0d", k), 64'(result[32*k +: 32]),
          (k < 3) ? 64'(32'hD0D0_0000 + 32'(k)) : 64'd0);

    // Job 3: new start clears err/result; start while busy is ignored
    clear_stats();
    never_idx = -1;
    pulse_start();
    chk("j3_err_cleared", 64'(err), 64'd0);
    chk("j3_result_cleared", 64'(result == '0), 64'd1);
    chk("j3_busy", 64'(busy), 64'd1);
    begin
      int n = 0;
      while (xfer_n < 5 && n < 200) begin
        step();
        n++;
      end
    end
    chk("j3_reached_wr_in", 64'(xfer_n >= 5), 64'd1);
    pulse_start();
    wait_done(400);
    repeat (4) step();
    chk("j3_xfers", 64'(xfer_n), 64'd16);
    chk("j3_done_pulses", 64'(done_cnt), 64'd1);
    chk("j3_busy_cycles", 64'(busy_cnt), 64'd97);
    chk("j3_err", 64'(err), 64'd0);
    for (int k = 0; k < int'(NUM_RD); k++)
      chk($sformatf("j3_result_%0d", k), 64'(result[32*k +: 32]), 64'(32'hD0D0_0000 + 32'(k)));

    // Job 4: asynchronous reset in the middle of a read
    clear_stats();
    pulse_start();
    begin
      int n = 0;
      while (!(xfer_n >= 12 && stb && !we) && n < 300) begin
        step();
        n++;
      end
    end
    chk("j4_reached_rd", 64'(xfer_n >= 12 && stb && !we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("j4_async_rst");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("j4_no_done", 64'(done_cnt), 64'd0);
    chk("j4_busy", 64'(busy), 64'd0);
    chk("j4_stb", 64'(stb), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
